des_trama_par: RTL and testbench
================================

Name: des_trama_par

Overview:
- Serial-to-parallel frame receiver that sits directly downstream of the serial sync-sequence detector.
- Its sync_ok input is driven by the detector's valido output.
- While sync is held, it slices the serial stream into fixed words of W data bits (MSB first) plus one parity bit.
- It emits each word with a one-cycle valid pulse, checks parity, and counts words and errors.
- After ERR_MAX consecutive parity errors it declares loss of sync and waits for the detector to drop and re-acquire.

Parameters:
- W, 8, data bits per word.
- PARITY_ODD, 0, 0 = even parity (XOR of data and parity bit = 0), 1 = odd parity (XOR = 1).
- ERR_MAX, 3, consecutive parity errors that force loss of sync (legal range 1..15).
- CNT_W, 8, width of the word and error counters.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-low.
- s_in  in  1  serial data bit, sampled every posedge.
- sync_ok  in  1  sync indication from the detector (valido); level.
- data_out  out  W  last received word; MSB = first data bit received.
- data_vld  out  1  one-cycle pulse, data_out updated.
- par_err  out  1  one-cycle pulse coincident with data_vld when parity fails.
- loss_sync  out  1  level; high while in HOLD.
- word_cnt  out  CNT_W  words delivered since reset (errored words included); saturates at all-ones.
- err_cnt  out  CNT_W  total parity errors since reset; saturates at all-ones.

Behaviour:
- Reset (rst=0 at a posedge) has priority over everything, including mid-word.
  - State = IDLE.
  - data_out = 0, data_vld = 0, par_err = 0, loss_sync = 0.
  - word_cnt = 0, err_cnt = 0, bit counter = 0, consecutive-error counter = 0.
- All outputs are registered.
- Four states, one-hot encoded: IDLE, RECV, PAR, HOLD.
- IDLE:
  - At an edge with sync_ok=1: go to RECV with bit counter = 0.
  - s_in at that edge is not used.
- RECV:
  - At an edge with sync_ok=1: shift s_in into the shift register (MSB first) and increment the bit counter.
  - After the W-th data bit, go to PAR.
- PAR:
  - At an edge with sync_ok=1, s_in is the parity bit.
  - Register data_out = the shifted word.
  - data_vld = 1 for exactly the next cycle.
  - par_err = 1 in that same cycle if the parity check fails.
  - Then go to RECV with bit counter = 0: back-to-back words, W+1 cycles per word, no idle bit.
- sync_ok=0 at any edge while in RECV or PAR:
  - Discard the partial word; no data_vld.
  - Go to IDLE.
  - Clear the consecutive-error counter.
- Error accounting in PAR:
  - Good parity clears the consecutive-error counter.
  - Bad parity increments it and increments err_cnt (saturating).
  - word_cnt increments (saturating) on every delivered word.
- Loss of sync: when the consecutive-error counter reaches ERR_MAX, the word is still delivered with par_err=1, the next state is HOLD, and loss_sync=1 from the same cycle as that data_vld.
- HOLD:
  - Ignores s_in.
  - Stays in HOLD while sync_ok=1.
  - At the first edge with sync_ok=0: go to IDLE, loss_sync=0, consecutive-error counter cleared.
- data_out holds its value between pulses.
- data_vld and par_err are 0 outside their pulse cycle.
- Counter saturation: at all-ones, further increments are ignored and there is no wrap.

Test Plan:
- Reset mid-word: drive sync_ok=1, send 4 bits, pull rst=0 for 1 cycle.
  - All outputs 0, state IDLE.
  - With sync_ok still 1, the next word is received cleanly from a fresh IDLE->RECV edge.
- Basic word (W=8, even parity): sync_ok=1, then bits 1,0,1,0,0,1,0,1 and parity 0.
  - data_out=8'hA5 with data_vld=1 for one cycle, in the cycle after the parity edge.
  - par_err=0, word_cnt=1.
- Back-to-back words: 8'h3C (parity 0) immediately followed by 8'hFF (parity 0).
  - Two data_vld pulses exactly 9 cycles apart.
  - word_cnt=2, err_cnt=0.
- Parity error: 8'h01 sent with parity 0.
  - data_out=8'h01, data_vld=1, par_err=1, err_cnt=1, loss_sync=0.
- Loss of sync (ERR_MAX=3): three consecutive bad-parity words.
  - Third pulse has par_err=1 and loss_sync=1.
  - Further bits produce no data_vld while sync_ok=1.
  - sync_ok=0 for 1 cycle clears loss_sync.
  - Re-raising sync_ok receives 8'hA5 correctly.
- Sync drop mid-word: sync_ok falls after 5 data bits.
  - No data_vld, word_cnt unchanged.
  - The next sync_ok rise starts a fresh word that decodes correctly.

Source files
------------

// File: rtl/des_trama_par_if.sv
// Bus between the frame receiver and its environment.
// The serial side carries the bit stream and the sync level from the detector.
// The parallel side carries the decoded word, its status pulses and the statistics counters.
interface des_trama_par_if #(
    parameter int W     = 8,
    parameter int CNT_W = 8
);
    logic             s_in;
    logic             sync_ok;
    logic [W-1:0]     data_out;
    logic             data_vld;
    logic             par_err;
    logic             loss_sync;
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] err_cnt;

    // The environment drives the serial side and observes the decoded side.
    modport master (
        output s_in, sync_ok,
        input  data_out, data_vld, par_err, loss_sync, word_cnt, err_cnt
    );

    // The receiver consumes the serial side and produces the decoded side.
    modport slave (
        input  s_in, sync_ok,
        output data_out, data_vld, par_err, loss_sync, word_cnt, err_cnt
    );
endinterface

// File: rtl/des_trama_par.sv
// Serial-to-parallel frame receiver placed after the sync-sequence detector.
// While sync is held, each word is W data bits sent MSB first, followed by one parity bit.
// Words arrive back to back with no gap between them.
// Each word is delivered with a one-cycle valid pulse and its parity is checked.
// ERR_MAX consecutive parity errors park the receiver in HOLD until the detector drops sync.
module des_trama_par #(
    parameter int W          = 8,
    parameter bit PARITY_ODD = 1'b0,
    parameter int ERR_MAX    = 3,
    parameter int CNT_W      = 8
) (
    input  logic           clk,
    input  logic           rst,
    des_trama_par_if.slave bus
);

    localparam int BCW = $clog2(W + 1);
    localparam int CW  = 4;

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        RECV = 4'b0010,
        PAR  = 4'b0100,
        HOLD = 4'b1000
    } state_t;

    state_t           state_q, state_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [W-1:0]     shift_q, shift_d;
    logic [W-1:0]     data_q, data_d;
    logic             vld_q, vld_d;
    logic             perr_q, perr_d;
    logic             loss_q, loss_d;
    logic [CNT_W-1:0] word_q, word_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [CW-1:0]    consec_q, consec_d;
    logic             parityBad;
    logic [CW-1:0]    consecInc;

    // Next state and next values of all registered outputs, counters and datapath.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        vld_d     = 1'b0;
        perr_d    = 1'b0;
        word_d    = word_q;
        err_d     = err_q;
        consec_d  = consec_q;
        parityBad = ((^shift_q) ^ bus.s_in) != PARITY_ODD;
        consecInc = consec_q + CW'(1);

        case (state_q)
            IDLE: begin
                if (bus.sync_ok) begin
                    state_d   = RECV;
                    bit_cnt_d = '0;
                end
            end
            RECV: begin
                if (!bus.sync_ok) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    consec_d  = '0;
                end else begin
                    shift_d   = {shift_q[W-2:0], bus.s_in};
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                    if (bit_cnt_q == BCW'(W - 1)) begin
                        state_d = PAR;
                    end
                end
            end
            PAR: begin
                if (!bus.sync_ok) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    consec_d  = '0;
                end else begin
                    data_d    = shift_q;
                    vld_d     = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = RECV;
                    if (word_q != {CNT_W{1'b1}}) begin
                        word_d = word_q + CNT_W'(1);
                    end
                    if (parityBad) begin
                        perr_d   = 1'b1;
                        consec_d = consecInc;
                        if (err_q != {CNT_W{1'b1}}) begin
                            err_d = err_q + CNT_W'(1);
                        end
                        if (consecInc == CW'(ERR_MAX)) begin
                            state_d = HOLD;
                        end
                    end else begin
                        consec_d = '0;
                    end
                end
            end
            HOLD: begin
                if (!bus.sync_ok) begin
                    state_d  = IDLE;
                    consec_d = '0;
                end
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
                consec_d  = '0;
            end
        endcase

        loss_d = (state_d == HOLD);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            vld_q     <= 1'b0;
            perr_q    <= 1'b0;
            loss_q    <= 1'b0;
            word_q    <= '0;
            err_q     <= '0;
            consec_q  <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            vld_q     <= vld_d;
            perr_q    <= perr_d;
            loss_q    <= loss_d;
            word_q    <= word_d;
            err_q     <= err_d;
            consec_q  <= consec_d;
        end
    end

    assign bus.data_out  = data_q;
    assign bus.data_vld  = vld_q;
    assign bus.par_err   = perr_q;
    assign bus.loss_sync = loss_q;
    assign bus.word_cnt  = word_q;
    assign bus.err_cnt   = err_q;

endmodule

// File: tb/tb_des_trama_par.sv
// Directed testbench for the serial frame receiver (W=8, even parity, ERR_MAX=3).
// Inputs change 1 time unit after each rising edge.
// Outputs are sampled at that same point, so they show what the preceding edge registered.
module tb_des_trama_par;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    des_trama_par_if #(.W(8), .CNT_W(8)) bus ();

    des_trama_par #(
        .W(8),
        .PARITY_ODD(1'b0),
        .ERR_MAX(3),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic sync, input logic sbit);
        bus.sync_ok = sync;
        bus.s_in    = sbit;
        @(posedge clk);
        #1;
    endtask

    task automatic sendWord(input logic [7:0] w, input logic p);
        for (int i = 7; i >= 0; i--) applyStimulus(1'b1, w[i]);
        applyStimulus(1'b1, p);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        rst = 1'b1;
        total++; if (bus.data_out !== 8'h00) begin bad++; $display("[TB] FAIL reset_data got=%h exp=%h", bus.data_out, 8'h00); end
        total++; if (bus.data_vld !== 1'b0) begin bad++; $display("[TB] FAIL reset_vld got=%b exp=0", bus.data_vld); end
        total++; if (bus.word_cnt !== 8'd0) begin bad++; $display("[TB] FAIL reset_words got=%0d exp=0", bus.word_cnt); end
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1);
        rst = 1'b1;
        total++; if ({bus.data_vld, bus.par_err, bus.loss_sync} !== 3'b000) begin bad++; $display("[TB] FAIL midreset_flags got=%b exp=000", {bus.data_vld, bus.par_err, bus.loss_sync}); end
        total++; if (bus.err_cnt !== 8'd0) begin bad++; $display("[TB] FAIL midreset_errs got=%0d exp=0", bus.err_cnt); end
        applyStimulus(1'b1, 1'b1);
        sendWord(8'hA5, 1'b0);
        total++; if (bus.data_out !== 8'hA5) begin bad++; $display("[TB] FAIL postreset_data got=%h exp=a5", bus.data_out); end
        total++; if (bus.data_vld !== 1'b1) begin bad++; $display("[TB] FAIL postreset_vld got=%b exp=1", bus.data_vld); end
        total++; if (bus.word_cnt !== 8'd1) begin bad++; $display("[TB] FAIL postreset_words got=%0d exp=1", bus.word_cnt); end
    endtask

    task automatic test_basic;
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        sendWord(8'hA5, 1'b0);
        total++; if (bus.data_out !== 8'hA5) begin bad++; $display("[TB] FAIL basic_data got=%h exp=a5", bus.data_out); end
        total++; if ({bus.data_vld, bus.par_err} !== 2'b10) begin bad++; $display("[TB] FAIL basic_vld_perr got=%b exp=10", {bus.data_vld, bus.par_err}); end
        total++; if (bus.word_cnt !== 8'd2) begin bad++; $display("[TB] FAIL basic_words got=%0d exp=2", bus.word_cnt); end
        applyStimulus(1'b0, 1'b1);
        total++; if (bus.data_vld !== 1'b0) begin bad++; $display("[TB] FAIL basic_pulse_width got=%b exp=0", bus.data_vld); end
        total++; if (bus.data_out !== 8'hA5) begin bad++; $display("[TB] FAIL basic_data_hold got=%h exp=a5", bus.data_out); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] w;
        applyStimulus(1'b1, 1'b0);
        sendWord(8'h3C, 1'b0);
        total++; if ({bus.data_vld, bus.data_out} !== {1'b1, 8'h3C}) begin bad++; $display("[TB] FAIL b2b_first got=%b/%h exp=1/3c", bus.data_vld, bus.data_out); end
        w = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, (i < 8) ? w[7-i] : 1'b0);
            total++; if (bus.data_vld !== (i == 8)) begin bad++; $display("[TB] FAIL b2b_spacing cycle=%0d got=%b exp=%b", i + 1, bus.data_vld, (i == 8)); end
        end
        total++; if (bus.data_out !== 8'hFF) begin bad++; $display("[TB] FAIL b2b_second got=%h exp=ff", bus.data_out); end
        total++; if ({bus.word_cnt, bus.err_cnt} !== {8'd4, 8'd0}) begin bad++; $display("[TB] FAIL b2b_counts got=%0d/%0d exp=4/0", bus.word_cnt, bus.err_cnt); end
        applyStimulus(1'b0, 1'b0);
    endtask

    task automatic test_parity_error;
        applyStimulus(1'b1, 1'b0);
        sendWord(8'h01, 1'b0);
        total++; if (bus.data_out !== 8'h01) begin bad++; $display("[TB] FAIL perr_data got=%h exp=01", bus.data_out); end
        total++; if ({bus.data_vld, bus.par_err, bus.loss_sync} !== 3'b110) begin bad++; $display("[TB] FAIL perr_flags got=%b exp=110", {bus.data_vld, bus.par_err, bus.loss_sync}); end
        total++; if (bus.err_cnt !== 8'd1) begin bad++; $display("[TB] FAIL perr_errs got=%0d exp=1", bus.err_cnt); end
        applyStimulus(1'b0, 1'b0);
        total++; if (bus.par_err !== 1'b0) begin bad++; $display("[TB] FAIL perr_pulse_width got=%b exp=0", bus.par_err); end
    endtask

    task automatic test_loss_sync;
        applyStimulus(1'b1, 1'b0);
        sendWord(8'h01, 1'b0);
        total++; if ({bus.par_err, bus.loss_sync} !== 2'b10) begin bad++; $display("[TB] FAIL loss_first got=%b exp=10", {bus.par_err, bus.loss_sync}); end
        sendWord(8'h80, 1'b0);
        total++; if ({bus.par_err, bus.loss_sync} !== 2'b10) begin bad++; $display("[TB] FAIL loss_second got=%b exp=10", {bus.par_err, bus.loss_sync}); end
        sendWord(8'h07, 1'b0);
        total++; if ({bus.data_vld, bus.par_err, bus.loss_sync} !== 3'b111) begin bad++; $display("[TB] FAIL loss_third got=%b exp=111", {bus.data_vld, bus.par_err, bus.loss_sync}); end
        total++; if ({bus.word_cnt, bus.err_cnt} !== {8'd8, 8'd4}) begin bad++; $display("[TB] FAIL loss_counts got=%0d/%0d exp=8/4", bus.word_cnt, bus.err_cnt); end
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'($urandom_range(0, 1)));
            total++; if ({bus.data_vld, bus.loss_sync} !== 2'b01) begin bad++; $display("[TB] FAIL hold_quiet cycle=%0d got=%b exp=01", i, {bus.data_vld, bus.loss_sync}); end
        end
        applyStimulus(1'b0, 1'b0);
        total++; if (bus.loss_sync !== 1'b0) begin bad++; $display("[TB] FAIL loss_clear got=%b exp=0", bus.loss_sync); end
        applyStimulus(1'b1, 1'b0);
        sendWord(8'hA5, 1'b0);
        total++; if ({bus.data_vld, bus.par_err, bus.data_out} !== {2'b10, 8'hA5}) begin bad++; $display("[TB] FAIL reacquire got=%b%b/%h exp=10/a5", bus.data_vld, bus.par_err, bus.data_out); end
        total++; if (bus.word_cnt !== 8'd9) begin bad++; $display("[TB] FAIL reacquire_words got=%0d exp=9", bus.word_cnt); end
    endtask

    task automatic test_sync_drop;
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        total++; if (bus.data_vld !== 1'b0) begin bad++; $display("[TB] FAIL drop_vld got=%b exp=0", bus.data_vld); end
        total++; if (bus.word_cnt !== 8'd9) begin bad++; $display("[TB] FAIL drop_words got=%0d exp=9", bus.word_cnt); end
        applyStimulus(1'b1, 1'b1);
        sendWord(8'h96, 1'b0);
        total++; if ({bus.data_vld, bus.par_err, bus.data_out} !== {2'b10, 8'h96}) begin bad++; $display("[TB] FAIL drop_fresh got=%b%b/%h exp=10/96", bus.data_vld, bus.par_err, bus.data_out); end
        total++; if (bus.word_cnt !== 8'd10) begin bad++; $display("[TB] FAIL drop_fresh_words got=%0d exp=10", bus.word_cnt); end
    endtask

    task automatic test_saturation;
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 250; i++) sendWord(8'hA5, 1'b0);
        total++; if (bus.word_cnt !== 8'hFF) begin bad++; $display("[TB] FAIL sat_words got=%0d exp=255", bus.word_cnt); end
        total++; if (bus.err_cnt !== 8'd4) begin bad++; $display("[TB] FAIL sat_errs_before got=%0d exp=4", bus.err_cnt); end
        for (int r = 0; r < 90; r++) begin
            applyStimulus(1'b0, 1'b0);
            applyStimulus(1'b1, 1'b0);
            for (int k = 0; k < 3; k++) sendWord(8'h01, 1'b0);
        end
        total++; if (bus.err_cnt !== 8'hFF) begin bad++; $display("[TB] FAIL sat_errs got=%0d exp=255", bus.err_cnt); end
        total++; if ({bus.word_cnt, bus.loss_sync} !== {8'hFF, 1'b1}) begin bad++; $display("[TB] FAIL sat_words_hold got=%0d/%b exp=255/1", bus.word_cnt, bus.loss_sync); end
    endtask

    // Runs every scenario in order; counters carry over, so expectations are cumulative.
    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b0;
        bus.sync_ok = 1'b0;
        bus.s_in    = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_parity_error();
        test_loss_sync();
        test_sync_drop();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
